scope_raster_renderer: RTL and testbench
========================================

# scope_raster_renderer

Parametrised raster engine that paints a multi-channel oscilloscope frame onto the LT24 panel. It fetches each row's samples from the capture memory, then streams one pixel per handshake into the `LT24Display` pixel port (`xAddr`, `yAddr`, `pixelData`, `pixelWrite`, `pixelReady`). It supports a configurable channel count, per-channel trace colours, a grid overlay, and single-shot or continuous frame modes. It replaces the free-running x/y counter pair in the scope top level.

## Interface
Parameters:
- `WIDTH`, 240: pixels per row (x extent); `xAddr` counts 0..WIDTH-1.
- `HEIGHT`, 320: rows per frame (y extent, time axis); `yAddr` counts 0..HEIGHT-1.
- `CHANNELS`, 2: trace channels, 1..4.
- `SAMPLE_W`, 8: sample width, must be ≥8.
- `GRID_PITCH`, 40: grid line spacing in pixels, both axes.
- `TRACE_COLOURS`, `{16'h07FF,16'hFFE0}`: 16·CHANNELS bits, RGB565; channel c uses bits [16c+15:16c].
- `BG_COLOUR`, 16'h0000; `GRID_COLOUR`, 16'h4208.

Ports:
- `clock` in 1: sole clock.
- `rstApp` in 1: reset. Synchronous, active-high.
- `frameStart` in 1: start one frame; honoured only in IDLE.
- `continuous` in 1: sampled in DONE; if high, the next frame starts without `frameStart`.
- `sampleCh` out 2: channel select for the capture-memory read.
- `sampleIdx` out 9: sample index for the read; equals the current row.
- `sampleRdEn` out 1: read strobe. Data returns on `sampleData` exactly 1 cycle later.
- `sampleData` in SAMPLE_W: read data.
- `xAddr` out 8, `yAddr` out 9, `pixelData` out 16: pixel to draw.
- `pixelWrite` out 1: pixel valid.
- `pixelReady` in 1: display accepts the pixel.
- `busy` out 1: high outside IDLE.
- `frameDone` out 1: one-cycle pulse in DONE.

## Operation
- FSM states: IDLE → FETCH → DRAW → (FETCH | DONE) → (IDLE | FETCH).
- **IDLE:** outputs are held at their reset values. `frameStart`=1 sets row to 0 and moves to FETCH.
- **FETCH:** lasts CHANNELS+1 cycles.
  - Cycles 0..CHANNELS-1: `sampleRdEn`=1, `sampleCh`=k, `sampleIdx`=row.
  - Cycles 1..CHANNELS: latch `sampleData` into trace register k-1.
  - Then go to DRAW with x=0.
- **DRAW:** `pixelWrite`=1. `xAddr`/`yAddr`/`pixelData` describe the current pixel and are held stable until `pixelWrite && pixelReady`.
  - On acceptance, x increments.
  - If the accepted x was WIDTH-1 and row < HEIGHT-1: row increments, go to FETCH.
  - If the accepted x was WIDTH-1 and row = HEIGHT-1: go to DONE.
- **DONE:** `frameDone`=1 for this one cycle only.
  - `continuous`=1: row=0, go to FETCH.
  - `continuous`=0: go to IDLE.
- **Trace position:** trace x = sample[SAMPLE_W-1 -: 8]. Values ≥ WIDTH clamp to WIDTH-1.
- **Pixel colour priority:**
  1. Lowest-index channel whose trace x equals `xAddr`.
  2. Otherwise grid, when `xAddr` or `yAddr` is a multiple of GRID_PITCH (including 0).
  3. Otherwise BG_COLOUR.
- **Grid detection:** uses per-axis pitch counters reloaded at row/frame start. No divider.
- `frameStart` while busy is ignored; it is not queued.

## Timing
- **Reset:** all outputs are 0 (`xAddr`, `yAddr`, `pixelData`, `pixelWrite`, `sampleRdEn`, `sampleCh`, `sampleIdx`, `busy`, `frameDone`), state is IDLE, and trace registers are 0.
- **Reset mid-frame:** applies at the next edge regardless of handshake state. Any pending pixel is dropped and no `frameDone` is issued.
- **Frame start:** `frameStart` sampled high at edge N puts the FSM in FETCH from cycle N+1.
- **Frame length:** with `pixelReady` tied high, FETCH-start to DONE is HEIGHT·(WIDTH+CHANNELS+1) cycles. Defaults: 320·243 = 77,760 cycles.
- **Output coherence:** `pixelData` is valid in the same cycle as its `xAddr`/`yAddr` and has no extra latency.
- **Stalls:** `pixelReady` low stalls DRAW indefinitely with all pixel outputs frozen. FETCH is not stalled by `pixelReady`.
- **Row turn:** `pixelWrite` drops to 0 for the CHANNELS+1 FETCH cycles between rows.
- **Wrap-around:** x and y never exceed WIDTH-1 / HEIGHT-1, and `yAddr` returns to 0 only via DONE.
- **Simultaneous events:** `rstApp` beats `frameStart`. `frameStart` in DONE is ignored; only `continuous` selects the next frame.

## Configuration
- `SCOPE_GRID_EN` defined: grid logic and pitch counters are compiled in, with the priority described above.
- `SCOPE_GRID_EN` undefined: no grid hardware. Non-trace pixels are always BG_COLOUR; GRID_PITCH and GRID_COLOUR are unused.

## Test plan
- **Basic frame:** reset, `pixelReady`=1, `frameStart` pulse, memory returns 0x10 for ch0 and 0x80 for ch1.
  - Every row: pixel x=16 is 0xFFE0 and x=128 is 0x07FF.
  - With the grid enabled, x=40 is 0x4208; other non-grid pixels are 0x0000.
  - `frameDone` pulses at cycle 77,760 after FETCH start.
- **Handshake stall:** drop `pixelReady` for 5 cycles at x=100 on row 3 → outputs hold (x=100, y=3) and no pixel is skipped or duplicated; the accepted count stays 76,800.
- **Overlap and clamp:** both channels return 0x20 → x=32 shows the ch0 colour 0xFFE0. A sample of 0xFF → trace drawn at x=239.
- **Continuous mode:** `continuous`=1 through DONE → FETCH starts the next cycle with `yAddr`=0; `busy` stays high.
- **Mid-frame reset:** assert `rstApp` at row 150 → next cycle all outputs are 0, state is IDLE, and no `frameDone`. A `frameStart` while busy has no effect.
- **Build without `SCOPE_GRID_EN`:** x=40 on an empty trace row → 0x0000.

Source files
------------

// File: rtl/scope_raster_renderer.sv
// scope_raster_renderer: fetches per-row trace samples, then streams LT24 pixels.
// Define SCOPE_GRID_EN to compile in the grid overlay and its pitch counters.
module scope_raster_renderer #(
    parameter int WIDTH = 240,
    parameter int HEIGHT = 320,
    parameter int CHANNELS = 2,
    parameter int SAMPLE_W = 8,
    parameter int GRID_PITCH = 40,
    parameter logic [16*CHANNELS-1:0] TRACE_COLOURS = {16'h07FF, 16'hFFE0},
    parameter logic [15:0] BG_COLOUR = 16'h0000,
    parameter logic [15:0] GRID_COLOUR = 16'h4208
) (
    input  logic                clock,
    input  logic                rstApp,
    input  logic                frameStart,
    input  logic                continuous,
    output logic [1:0]          sampleCh,
    output logic [8:0]          sampleIdx,
    output logic                sampleRdEn,
    input  logic [SAMPLE_W-1:0] sampleData,
    output logic [7:0]          xAddr,
    output logic [8:0]          yAddr,
    output logic [15:0]         pixelData,
    output logic                pixelWrite,
    input  logic                pixelReady,
    output logic                busy,
    output logic                frameDone
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAW, S_DONE} state_t;

    localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
    localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);
    localparam logic [2:0] K_LAST = 3'(CHANNELS);

    if (CHANNELS < 1 || CHANNELS > 4 || SAMPLE_W < 8 || GRID_PITCH < 1 ||
        WIDTH < 1 || WIDTH > 256 || HEIGHT < 1 || HEIGHT > 512) begin : g_bad_cfg
        $error("scope_raster_renderer: unsupported parameter set");
    end

    state_t      state_q, state_d;
    logic [7:0]  x_q, x_d;
    logic [8:0]  row_q, row_d;
    logic [2:0]  k_q, k_d;
    logic [7:0]  trace_q [CHANNELS];
    logic [7:0]  trace_d [CHANNELS];
    logic [7:0]  raw_x;
    logic [7:0]  sample_x;
    logic        accept;
    logic        grid_hit;
    logic [15:0] colour;

`ifdef SCOPE_GRID_EN
    localparam int GW = $clog2(GRID_PITCH + 1);
    localparam logic [GW-1:0] G_LAST = GW'(GRID_PITCH - 1);

    logic [GW-1:0] gx_q, gx_d;
    logic [GW-1:0] gy_q, gy_d;

    // Counters sit at zero on every pitch multiple, so no divider is needed.
    assign grid_hit = (gx_q == '0) || (gy_q == '0);
`else
    assign grid_hit = 1'b0;
`endif

    assign raw_x    = sampleData[SAMPLE_W-1 -: 8];
    assign sample_x = (raw_x > X_LAST) ? X_LAST : raw_x;
    assign accept   = (state_q == S_DRAW) && pixelReady;

    always_ff @(posedge clock) begin
        if (rstApp) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (rstApp) begin
            x_q   <= '0;
            row_q <= '0;
            k_q   <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                trace_q[c] <= '0;
            end
`ifdef SCOPE_GRID_EN
            gx_q <= '0;
            gy_q <= '0;
`endif
        end else begin
            x_q     <= x_d;
            row_q   <= row_d;
            k_q     <= k_d;
            trace_q <= trace_d;
`ifdef SCOPE_GRID_EN
            gx_q <= gx_d;
            gy_q <= gy_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        row_d   = row_q;
        k_d     = k_q;
        trace_d = trace_q;
`ifdef SCOPE_GRID_EN
        gx_d = gx_q;
        gy_d = gy_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (frameStart) begin
                    state_d = S_FETCH;
                    row_d   = '0;
                    k_d     = '0;
`ifdef SCOPE_GRID_EN
                    gy_d = '0;
`endif
                end
            end
            S_FETCH: begin
                k_d = k_q + 3'd1;
                // Read data for channel k-1 lands one cycle after its strobe.
                for (int c = 0; c < CHANNELS; c++) begin
                    if (k_q == 3'(c + 1)) begin
                        trace_d[c] = sample_x;
                    end
                end
                if (k_q == K_LAST) begin
                    state_d = S_DRAW;
                    x_d     = '0;
                    k_d     = '0;
`ifdef SCOPE_GRID_EN
                    gx_d = '0;
`endif
                end
            end
            S_DRAW: begin
                if (accept) begin
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (row_q == Y_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_FETCH;
                            row_d   = row_q + 9'd1;
`ifdef SCOPE_GRID_EN
                            gy_d = (gy_q == G_LAST) ? '0 : gy_q + 1'b1;
`endif
                        end
                    end else begin
                        x_d = x_q + 8'd1;
`ifdef SCOPE_GRID_EN
                        gx_d = (gx_q == G_LAST) ? '0 : gx_q + 1'b1;
`endif
                    end
                end
            end
            S_DONE: begin
                row_d   = '0;
                k_d     = '0;
                state_d = continuous ? S_FETCH : S_IDLE;
`ifdef SCOPE_GRID_EN
                gy_d = '0;
`endif
            end
        endcase
    end

    // Lowest channel wins, so walk from the highest index down.
    always_comb begin
        colour = grid_hit ? GRID_COLOUR : BG_COLOUR;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (trace_q[c] == x_q) begin
                colour = TRACE_COLOURS[16*c +: 16];
            end
        end
    end

    always_comb begin
        busy       = 1'b0;
        frameDone  = 1'b0;
        pixelWrite = 1'b0;
        pixelData  = '0;
        sampleRdEn = 1'b0;
        sampleCh   = '0;
        sampleIdx  = '0;
        xAddr      = x_q;
        yAddr      = row_q;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_FETCH: begin
                busy = 1'b1;
                if (k_q != K_LAST) begin
                    sampleRdEn = 1'b1;
                    sampleCh   = k_q[1:0];
                    sampleIdx  = row_q;
                end
            end
            S_DRAW: begin
                busy       = 1'b1;
                pixelWrite = 1'b1;
                pixelData  = colour;
            end
            S_DONE: begin
                busy      = 1'b1;
                frameDone = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_scope_raster_renderer.sv
// Directed bench for scope_raster_renderer on a short 240x8 frame.
// Grid expectations follow SCOPE_GRID_EN the same way the RTL does.
module tb_scope_raster_renderer;
    localparam int W = 240;
    localparam int H = 8;
    localparam int NCH = 2;
    localparam int FRAME_CYC = H * (W + NCH + 1);
    localparam logic [15:0] C0 = 16'hFFE0;
    localparam logic [15:0] C1 = 16'h07FF;
`ifdef SCOPE_GRID_EN
    localparam logic [15:0] GC = 16'h4208;
`else
    localparam logic [15:0] GC = 16'h0000;
`endif

    logic        clock = 1'b0;
    logic        rstApp;
    logic        frameStart;
    logic        continuous;
    logic [1:0]  sampleCh;
    logic [8:0]  sampleIdx;
    logic        sampleRdEn;
    logic [7:0]  sampleData = '0;
    logic [7:0]  xAddr;
    logic [8:0]  yAddr;
    logic [15:0] pixelData;
    logic        pixelWrite;
    logic        pixelReady;
    logic        busy;
    logic        frameDone;

    logic [7:0]  mem [4];
    logic [15:0] fb [H][W];
    int          n_chk = 0;
    int          n_bad = 0;
    int          cycles = 0;
    int          acc = 0;
    int          ex = 0;
    int          ey = 0;
    int          t0;
    int          t1;
    int          n;

    scope_raster_renderer #(
        .WIDTH(W), .HEIGHT(H), .CHANNELS(NCH), .SAMPLE_W(8),
        .GRID_PITCH(40), .TRACE_COLOURS({16'h07FF, 16'hFFE0}),
        .BG_COLOUR(16'h0000), .GRID_COLOUR(16'h4208)
    ) dut (
        .clock(clock), .rstApp(rstApp), .frameStart(frameStart),
        .continuous(continuous), .sampleCh(sampleCh), .sampleIdx(sampleIdx),
        .sampleRdEn(sampleRdEn), .sampleData(sampleData), .xAddr(xAddr),
        .yAddr(yAddr), .pixelData(pixelData), .pixelWrite(pixelWrite),
        .pixelReady(pixelReady), .busy(busy), .frameDone(frameDone)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycles <= cycles + 1;

    // Capture memory: one-cycle read latency, same value for every row.
    always @(posedge clock) if (sampleRdEn) sampleData <= mem[sampleCh];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Accepted-pixel scoreboard: raster order, count, and a frame buffer.
    always @(negedge clock) begin
        if (!busy) begin
            acc = 0;
            ex = 0;
            ey = 0;
        end else if (pixelWrite && pixelReady) begin
            chk("order_x", xAddr, ex);
            chk("order_y", yAddr, ey);
            if (xAddr < W && yAddr < H) fb[yAddr][xAddr] = pixelData;
            acc++;
            if (ex == W - 1) begin
                ex = 0;
                ey = (ey == H - 1) ? 0 : ey + 1;
            end else begin
                ex++;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_frame();
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
    endtask

    task automatic wait_done(output int t);
        int k;
        k = 0;
        while (!frameDone && k < 3 * FRAME_CYC) begin
            tick();
            k++;
        end
        chk("done_seen", frameDone, 1);
        t = cycles;
    endtask

    initial begin
        rstApp = 1'b1;
        frameStart = 1'b0;
        continuous = 1'b0;
        pixelReady = 1'b1;
        mem[0] = 8'h10;
        mem[1] = 8'h80;
        mem[2] = 8'h00;
        mem[3] = 8'h00;
        tick();
        tick();
        chk("rst_xy", {yAddr, xAddr}, 0);
        chk("rst_px", {pixelData, pixelWrite, frameDone, busy}, 0);
        chk("rst_rd", {sampleRdEn, sampleCh, sampleIdx}, 0);
        rstApp = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // Basic frame
        start_frame();
        t0 = cycles;
        chk("f1_busy", busy, 1);
        chk("f1_rd0", {sampleRdEn, sampleCh}, 3'b100);
        chk("f1_idx", sampleIdx, 0);
        chk("f1_nowr", pixelWrite, 0);
        tick();
        chk("f1_rd1", {sampleRdEn, sampleCh}, 3'b101);
        wait_done(t1);
        chk("f1_len", t1 - t0, FRAME_CYC);
        chk("f1_acc", acc, W * H);
        chk("f1_ylast", yAddr, H - 1);
        tick();
        chk("f1_pulse", frameDone, 0);
        chk("f1_idle", busy, 0);
        for (int r = 0; r < H; r++) begin
            chk("f1_x16", fb[r][16], C0);
            chk("f1_x128", fb[r][128], C1);
        end
        chk("f1_x40", fb[1][40], GC);
        chk("f1_x41", fb[1][41], 0);
        chk("f1_row0", fb[0][41], GC);
        chk("f1_x0", fb[2][0], GC);
        chk("f1_x239", fb[5][239], 0);

        // Overlap, stall, frameStart while busy
        mem[0] = 8'h20;
        mem[1] = 8'h20;
        start_frame();
        t0 = cycles;
        repeat (10) tick();
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        n = 0;
        while (!(pixelWrite && xAddr == 100 && yAddr == 3) && n < 3000) begin
            tick();
            n++;
        end
        chk("stall_reach", {yAddr, xAddr}, {9'd3, 8'd100});
        pixelReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_xy", {yAddr, xAddr}, {9'd3, 8'd100});
            chk("stall_wr", pixelWrite, 1);
            chk("stall_px", pixelData, 0);
        end
        pixelReady = 1'b1;
        wait_done(t1);
        chk("f2_len", t1 - t0, FRAME_CYC + 5);
        chk("f2_acc", acc, W * H);
        tick();
        tick();
        chk("no_queue", busy, 0);
        chk("ovl_x32", fb[4][32], C0);
        chk("ovl_x33", fb[4][33], 0);

        // Continuous mode with clamped trace
        mem[0] = 8'hFF;
        mem[1] = 8'h40;
        continuous = 1'b1;
        start_frame();
        t0 = cycles;
        wait_done(t1);
        chk("c1_len", t1 - t0, FRAME_CYC);
        tick();
        chk("c_busy", busy, 1);
        chk("c_y0", yAddr, 0);
        chk("c_rd", {sampleRdEn, sampleCh, sampleIdx}, 12'h800);
        chk("c_pulse", frameDone, 0);
        t0 = cycles;
        continuous = 1'b0;
        wait_done(t1);
        chk("c2_len", t1 - t0, FRAME_CYC);
        chk("c_acc", acc, 2 * W * H);
        tick();
        chk("c_idle", busy, 0);
        chk("clamp_239", fb[2][239], C0);
        chk("c_x64", fb[6][64], C1);
        chk("c_x238", fb[6][238], 0);

        // Mid-frame reset racing a frameStart
        mem[0] = 8'h10;
        mem[1] = 8'h80;
        start_frame();
        n = 0;
        while (yAddr != 5 && n < 3000) begin
            tick();
            n++;
        end
        chk("mr_reach", yAddr, 5);
        rstApp = 1'b1;
        frameStart = 1'b1;
        tick();
        rstApp = 1'b0;
        frameStart = 1'b0;
        chk("mr_xy", {yAddr, xAddr}, 0);
        chk("mr_px", {pixelData, pixelWrite, frameDone, busy}, 0);
        chk("mr_rd", {sampleRdEn, sampleCh, sampleIdx}, 0);
        n = 0;
        repeat (2500) begin
            tick();
            if (frameDone || busy) n++;
        end
        chk("mr_quiet", n, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
